// File: rtl/arm_multicycle_ctrl_pkg.sv
// Shared types and encodings for the multicycle ARM controller.
// Latency: none (definitions only).
// Backpressure: not applicable.
package arm_multicycle_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXECR  = 4'd6,
        S_EXECI  = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9
    } state_t;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    // Condition field encodings (AL = 4'hE, 4'hF never executes).
    localparam logic [3:0] CC_EQ = 4'h0, CC_NE = 4'h1, CC_CS = 4'h2, CC_CC = 4'h3;
    localparam logic [3:0] CC_MI = 4'h4, CC_PL = 4'h5, CC_VS = 4'h6, CC_VC = 4'h7;
    localparam logic [3:0] CC_HI = 4'h8, CC_LS = 4'h9, CC_GE = 4'hA, CC_LT = 4'hB;
    localparam logic [3:0] CC_GT = 4'hC, CC_LE = 4'hD, CC_AL = 4'hE;

    // ALU operation for a data-processing cmd; unsupported cmds fall back to ADD.
    function automatic logic [1:0] dp_alu_ctl(input logic [3:0] cmd);
        case (cmd)
            CMD_ADD:          return ALU_ADD;
            CMD_SUB, CMD_CMP: return ALU_SUB;
            CMD_AND:          return ALU_AND;
            CMD_ORR:          return ALU_ORR;
            default:          return ALU_ADD;
        endcase
    endfunction

    // True when a data-processing cmd writes its destination register.
    function automatic logic dp_writes_rd(input logic [3:0] cmd);
        return (cmd == CMD_ADD) || (cmd == CMD_SUB) ||
               (cmd == CMD_AND) || (cmd == CMD_ORR);
    endfunction

endpackage

// File: rtl/cond_logic.sv
// ARM condition-code evaluator against registered NZCV; only built with CONDEX_EN.
// Latency: combinational.
// Backpressure: not applicable.
`ifdef CONDEX_EN
module cond_logic
    import arm_multicycle_ctrl_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       cond_ex
);

    logic n, z, c, v;
    assign {n, z, c, v} = flags;

    // Evaluate the condition field; 4'hF is treated as never.
    always_comb begin
        cond_ex = 1'b0;
        case (cond)
            CC_EQ: cond_ex = z;
            CC_NE: cond_ex = !z;
            CC_CS: cond_ex = c;
            CC_CC: cond_ex = !c;
            CC_MI: cond_ex = n;
            CC_PL: cond_ex = !n;
            CC_VS: cond_ex = v;
            CC_VC: cond_ex = !v;
            CC_HI: cond_ex = c && !z;
            CC_LS: cond_ex = !c || z;
            CC_GE: cond_ex = (n == v);
            CC_LT: cond_ex = (n != v);
            CC_GT: cond_ex = !z && (n == v);
            CC_LE: cond_ex = z || (n != v);
            CC_AL: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

endmodule
`endif

// File: rtl/arm_multicycle_ctrl.sv
// Multicycle ARM controller FSM; optional conditional execution via CONDEX_EN.
// Latency: LDR 5, STR 4, DP 4, B 3, op=11 2 cycles; outputs are Moore decode of State/Instr.
// Backpressure: none; sync active-low reset forces FETCH and masks all enables.
module arm_multicycle_ctrl
    import arm_multicycle_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Instr,
    input  logic [3:0]  ALUFlags,
    output logic        PCWrite,
    output logic        IRWrite,
    output logic        MemWrite,
    output logic        RegWrite,
    output logic        AdrSrc,
    output logic        ALUSrcA,
    output logic [1:0]  ResultSrc,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ImmSrc,
    output logic [1:0]  RegSrc,
    output logic [1:0]  ALUControl,
    output logic [3:0]  State
);

    logic [3:0] cond, cmd, rd;
    logic [1:0] op;
    logic       i_bit, s_bit, l_bit;
    state_t     state;
    logic [3:0] nzcv;
    logic       cond_ex;
    logic       pc_we, ir_we, mem_we, reg_we;

    assign cond  = Instr[31:28];
    assign op    = Instr[27:26];
    assign i_bit = Instr[25];
    assign cmd   = Instr[24:21];
    assign s_bit = Instr[20];
    assign l_bit = Instr[20];
    assign rd    = Instr[15:12];

`ifdef CONDEX_EN
    cond_logic u_cond_logic (
        .cond    (cond),
        .flags   (nzcv),
        .cond_ex (cond_ex)
    );
`else
    assign cond_ex = 1'b1;
    logic unused_cond;
    assign unused_cond = ^{cond, nzcv};
`endif

    logic unused_instr;
    assign unused_instr = ^{Instr[19:16], Instr[11:0]};

    // State sequencing and flag capture at the ALUWB edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= S_FETCH;
            nzcv  <= '0;
        end else begin
            case (state)
                S_FETCH:  state <= S_DECODE;
                S_DECODE: begin
                    case (op)
                        OP_MEM:  state <= S_MEMADR;
                        OP_DP:   state <= i_bit ? S_EXECI : S_EXECR;
                        OP_BR:   state <= S_BRANCH;
                        default: state <= S_FETCH;
                    endcase
                end
                S_MEMADR: state <= l_bit ? S_MEMRD : S_MEMWR;
                S_MEMRD:  state <= S_MEMWB;
                S_EXECR,
                S_EXECI:  state <= S_ALUWB;
                default:  state <= S_FETCH;
            endcase
            if (state == S_ALUWB && s_bit && cond_ex)
                nzcv <= ALUFlags;
        end
    end

    // Moore decode of datapath controls from state and instruction fields.
    always_comb begin
        pc_we      = 1'b0;
        ir_we      = 1'b0;
        mem_we     = 1'b0;
        reg_we     = 1'b0;
        AdrSrc     = 1'b0;
        ALUSrcA    = 1'b0;
        ResultSrc  = 2'b00;
        ALUSrcB    = 2'b00;
        ALUControl = ALU_ADD;
        ImmSrc     = op;
        RegSrc     = (op == OP_BR)             ? 2'b01 :
                     (op == OP_MEM && !l_bit)  ? 2'b10 : 2'b00;
        case (state)
            S_FETCH: begin
                ir_we = 1'b1; pc_we = 1'b1;
                ALUSrcA = 1'b1; ALUSrcB = 2'b10; ResultSrc = 2'b10;
            end
            S_DECODE: begin
                ALUSrcA = 1'b1; ALUSrcB = 2'b10; ResultSrc = 2'b10;
            end
            S_MEMADR: ALUSrcB = 2'b01;
            S_MEMRD:  AdrSrc = 1'b1;
            S_MEMWB: begin
                ResultSrc = 2'b01;
                reg_we    = cond_ex;
                pc_we     = cond_ex && (rd == 4'd15);
            end
            S_MEMWR: begin
                AdrSrc = 1'b1;
                mem_we = cond_ex;
            end
            S_EXECR: ALUControl = dp_alu_ctl(cmd);
            S_EXECI: begin
                ALUSrcB    = 2'b01;
                ALUControl = dp_alu_ctl(cmd);
            end
            S_ALUWB: begin
                reg_we = cond_ex && dp_writes_rd(cmd);
                pc_we  = cond_ex && dp_writes_rd(cmd) && (rd == 4'd15);
            end
            S_BRANCH: begin
                ALUSrcB = 2'b01; ResultSrc = 2'b10;
                pc_we   = cond_ex;
            end
            default: ;
        endcase
    end

    // Reset masks every write enable in the cycle it is asserted.
    assign PCWrite  = pc_we  && reset;
    assign IRWrite  = ir_we  && reset;
    assign MemWrite = mem_we && reset;
    assign RegWrite = reg_we && reset;
    assign State    = state;

endmodule

// File: tb/tb_arm_multicycle_ctrl.sv
// Scoreboard bench for arm_multicycle_ctrl: per-cycle expected control vectors queued at issue.
// Latency: checks every cycle of each instruction, sampled 1ns after the falling edge.
// Backpressure: none; a watchdog bounds the run.
module tb_arm_multicycle_ctrl;
    import arm_multicycle_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] Instr;
    logic [3:0]  ALUFlags;
    logic        PCWrite, IRWrite, MemWrite, RegWrite, AdrSrc, ALUSrcA;
    logic [1:0]  ResultSrc, ALUSrcB, ImmSrc, RegSrc, ALUControl;
    logic [3:0]  State;

    always #5 clk = ~clk;

    arm_multicycle_ctrl dut (
        .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags),
        .PCWrite(PCWrite), .IRWrite(IRWrite), .MemWrite(MemWrite), .RegWrite(RegWrite),
        .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA), .ResultSrc(ResultSrc), .ALUSrcB(ALUSrcB),
        .ImmSrc(ImmSrc), .RegSrc(RegSrc), .ALUControl(ALUControl), .State(State)
    );

`ifdef CONDEX_EN
    localparam bit CX = 1'b1;
`else
    localparam bit CX = 1'b0;
`endif

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [19:0] exp_q[$];
    string       tag_q[$];
    logic [1:0]  imm_e, rsrc_e;
    logic [19:0] obs;

    assign obs = {State, PCWrite, IRWrite, MemWrite, RegWrite, AdrSrc, ALUSrcA,
                  ResultSrc, ALUSrcB, ImmSrc, RegSrc, ALUControl};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    function automatic logic [19:0] mk(input logic [3:0] st, input bit pcw, input bit irw,
                                       input bit mw, input bit rw, input bit adr, input bit asa,
                                       input logic [1:0] rs, input logic [1:0] asb,
                                       input logic [1:0] alc);
        return {st, pcw, irw, mw, rw, adr, asa, rs, asb, imm_e, rsrc_e, alc};
    endfunction

    task automatic push_exp(input string tag, input logic [19:0] v);
        exp_q.push_back(v);
        tag_q.push_back(tag);
    endtask

    // Drive one instruction and queue the expected vector of each of its cycles.
    task automatic push_instr(input string nm, input logic [31:0] ins, input logic [3:0] flg,
                              input bit pass, input logic [1:0] alc, input bit wr);
        logic [1:0] op;
        bit ld, rd15, imm;
        op   = ins[27:26];
        ld   = ins[20];
        imm  = ins[25];
        rd15 = (ins[15:12] == 4'hF);
        Instr    = ins;
        ALUFlags = flg;
        imm_e  = op;
        rsrc_e = (op == 2'b10) ? 2'b01 : ((op == 2'b01 && !ld) ? 2'b10 : 2'b00);
        push_exp({nm, "_fetch"},  mk(S_FETCH,  1, 1, 0, 0, 0, 1, 2'b10, 2'b10, 2'b00));
        push_exp({nm, "_decode"}, mk(S_DECODE, 0, 0, 0, 0, 0, 1, 2'b10, 2'b10, 2'b00));
        case (op)
            2'b01: begin
                push_exp({nm, "_memadr"}, mk(S_MEMADR, 0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b00));
                if (ld) begin
                    push_exp({nm, "_memrd"}, mk(S_MEMRD, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00));
                    push_exp({nm, "_memwb"}, mk(S_MEMWB, pass && rd15, 0, 0, pass, 0, 0,
                                                2'b01, 2'b00, 2'b00));
                end else begin
                    push_exp({nm, "_memwr"}, mk(S_MEMWR, 0, 0, pass, 0, 1, 0, 2'b00, 2'b00, 2'b00));
                end
            end
            2'b00: begin
                push_exp({nm, "_exec"}, mk(imm ? S_EXECI : S_EXECR, 0, 0, 0, 0, 0, 0, 2'b00,
                                           imm ? 2'b01 : 2'b00, alc));
                push_exp({nm, "_aluwb"}, mk(S_ALUWB, pass && wr && rd15, 0, 0, pass && wr, 0, 0,
                                            2'b00, 2'b00, 2'b00));
            end
            2'b10: push_exp({nm, "_branch"}, mk(S_BRANCH, pass, 0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00));
            default: ;
        endcase
    endtask

    // Compare n queued cycles, one per falling edge.
    task automatic drain(input int n);
        for (int i = 0; i < n; i++) begin
            #1;
            if (exp_q.size() == 0) chk("queue_empty", exp_q.size(), 1);
            else chk(tag_q.pop_front(), {12'b0, obs}, {12'b0, exp_q.pop_front()});
            @(negedge clk);
        end
    endtask

    task automatic run(input string nm, input logic [31:0] ins, input logic [3:0] flg,
                       input bit pass, input logic [1:0] alc, input bit wr);
        push_instr(nm, ins, flg, pass, alc, wr);
        drain(exp_q.size());
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; Instr = '0; ALUFlags = '0; imm_e = 2'b00; rsrc_e = 2'b00;
        @(negedge clk); @(negedge clk);
        push_exp("rst_fetch", mk(S_FETCH, 0, 0, 0, 0, 0, 1, 2'b10, 2'b10, 2'b00));
        drain(1);
        chk("rst_nzcv", {28'b0, dut.nzcv}, 32'h0);
        reset = 1'b1;

        run("add_pc0",   32'hE28F0000, 4'h0, 1'b1, ALU_ADD, 1'b1);
        run("ldr",       32'hE5910004, 4'h0, 1'b1, ALU_ADD, 1'b0);
        run("str",       32'hE5810004, 4'h0, 1'b1, ALU_ADD, 1'b0);
        run("sub_reg",   32'hE0421003, 4'h0, 1'b1, ALU_SUB, 1'b1);
        run("and_reg",   32'hE0021003, 4'h0, 1'b1, ALU_AND, 1'b1);
        run("orr_imm",   32'hE3821001, 4'h0, 1'b1, ALU_ORR, 1'b1);
        run("eor_unsup", 32'hE0221003, 4'h0, 1'b1, ALU_ADD, 1'b0);
        run("adds",      32'hE2921001, 4'b1001, 1'b1, ALU_ADD, 1'b1);
        chk("nzcv_adds", {28'b0, dut.nzcv}, 32'h9);
        run("add_r15",   32'hE28FF008, 4'h0, 1'b1, ALU_ADD, 1'b1);
        run("cmp",       32'hE3500000, 4'b0100, 1'b1, ALU_SUB, 1'b0);
        chk("nzcv_cmp", {28'b0, dut.nzcv}, 32'h4);
        run("bne",       32'h1AFFFFFE, 4'h0, !CX, ALU_ADD, 1'b0);
        run("beq",       32'h0AFFFFFE, 4'h0, 1'b1, ALU_ADD, 1'b0);
        run("addsne",    32'h12921001, 4'b0011, !CX, ALU_ADD, 1'b1);
        chk("nzcv_addsne", {28'b0, dut.nzcv}, CX ? 32'h4 : 32'h3);
        run("op11",      32'hEF000000, 4'h0, 1'b1, ALU_ADD, 1'b0);

        // Reset while the LDR sits in MEMRD, then hold reset through one FETCH.
        push_instr("ldr_rst", 32'hE5910004, 4'h0, 1'b1, ALU_ADD, 1'b0);
        drain(3);
        reset = 1'b0;
        drain(1);
        exp_q.delete();
        tag_q.delete();
        push_exp("rst_mid_fetch", mk(S_FETCH, 0, 0, 0, 0, 0, 1, 2'b10, 2'b10, 2'b00));
        drain(1);
        chk("rst_mid_nzcv", {28'b0, dut.nzcv}, 32'h0);
        reset = 1'b1;
        run("ldr_after", 32'hE5910004, 4'h0, 1'b1, ALU_ADD, 1'b0);
        run("str_after", 32'hE5810004, 4'h0, 1'b1, ALU_ADD, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
